// File: rtl/ascii_pkg.sv
// Shared definitions for the ASCII decimal token parser: state encoding,
// output width and the character codes the parser recognises.
package ascii_pkg;

  localparam int unsigned BIN_W = 20;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Carriage return, line feed and space all end a token.
  function automatic logic is_terminator(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF) || (c == ASCII_SP);
  endfunction

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational ASCII decimal digit decoder: flags '0'..'9' and yields the
// digit value (0 for any non-digit byte).
module ascii_digit_decode
  import ascii_pkg::*;
(
  input  logic [7:0] ascii_in,
  output logic [3:0] digit,
  output logic       is_digit
);

  // Range check on the full byte, value taken from the low nibble.
  always_comb begin
    is_digit = (ascii_in >= ASCII_0) && (ascii_in <= ASCII_9);
    digit    = is_digit ? ascii_in[3:0] : 4'd0;
  end

endmodule

// File: rtl/ascii_num_parser.sv
// ASCII decimal token parser: accumulates up to MAX_DIGITS digits and emits
// the binary value on a terminator (CR, LF or space).
// Optional feature: define ASCII_PARSER_SIGN_EN to accept a leading '-' and
// add the neg output.
module ascii_num_parser
  import ascii_pkg::*;
#(
  parameter int MAX_DIGITS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ascii_in,
  input  logic             ascii_valid,
  output logic             ascii_ready,
  output logic [BIN_W-1:0] bin_out,
  output logic             done,
  output logic             error,
`ifdef ASCII_PARSER_SIGN_EN
  output logic             neg,
`endif
  output logic             busy
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  state_t           state, state_nx;
  logic [BIN_W-1:0] acc, acc_nx, bin_nx, acc_x10;
  logic [2:0]       count, count_nx;
  logic             done_nx, error_nx;
  logic             ready_en;
  logic             accept, is_term, is_digit;
  logic [3:0]       digit;
`ifdef ASCII_PARSER_SIGN_EN
  logic             sign, sign_nx, neg_nx;
`endif

  ascii_digit_decode u_decode (
    .ascii_in (ascii_in),
    .digit    (digit),
    .is_digit (is_digit)
  );

  // Handshake and multiply-by-ten via shifts; the 24-bit sum is truncated to
  // 20 bits, which is lossless for values up to 999999.
  always_comb begin
    ascii_ready = ready_en && (state != DONE);
    accept      = ascii_valid && ascii_ready;
    is_term     = is_terminator(ascii_in);
    busy        = (state == ACCUM) || (state == DRAIN);
    acc_x10     = BIN_W'(({4'd0, acc} << 3) + ({4'd0, acc} << 1));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    count_nx = count;
    bin_nx   = bin_out;
    done_nx  = 1'b0;
    error_nx = 1'b0;
`ifdef ASCII_PARSER_SIGN_EN
    sign_nx  = sign;
    neg_nx   = neg;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_digit) begin
            state_nx = ACCUM;
            acc_nx   = {16'd0, digit};
            count_nx = 3'd1;
`ifdef ASCII_PARSER_SIGN_EN
            sign_nx  = 1'b0;
`endif
          end else if (is_term) begin
            state_nx = IDLE;
`ifdef ASCII_PARSER_SIGN_EN
          end else if (ascii_in == ASCII_MINUS) begin
            state_nx = ACCUM;
            acc_nx   = '0;
            count_nx = '0;
            sign_nx  = 1'b1;
`endif
          end else begin
            state_nx = DRAIN;
            error_nx = 1'b1;
            bin_nx   = '0;
`ifdef ASCII_PARSER_SIGN_EN
            neg_nx   = 1'b0;
`endif
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          if (is_digit && (count < MAX_CNT)) begin
            acc_nx   = acc_x10 + {16'd0, digit};
            count_nx = count + 3'd1;
          end else if (is_term && (count != '0)) begin
            state_nx = DONE;
            done_nx  = 1'b1;
            bin_nx   = acc;
`ifdef ASCII_PARSER_SIGN_EN
            neg_nx   = sign;
`endif
          end else begin
            // Overlong token, bad character, or a bare '-' terminated.
            state_nx = (is_term) ? IDLE : DRAIN;
            error_nx = 1'b1;
            bin_nx   = '0;
            acc_nx   = '0;
            count_nx = '0;
`ifdef ASCII_PARSER_SIGN_EN
            neg_nx   = 1'b0;
`endif
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        acc_nx   = '0;
        count_nx = '0;
`ifdef ASCII_PARSER_SIGN_EN
        sign_nx  = 1'b0;
`endif
      end
      DRAIN: begin
        if (accept && is_term) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      bin_out  <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      ready_en <= 1'b0;
`ifdef ASCII_PARSER_SIGN_EN
      sign     <= 1'b0;
      neg      <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      acc      <= acc_nx;
      count    <= count_nx;
      bin_out  <= bin_nx;
      done     <= done_nx;
      error    <= error_nx;
      ready_en <= 1'b1;
`ifdef ASCII_PARSER_SIGN_EN
      sign     <= sign_nx;
      neg      <= neg_nx;
`endif
    end
  end

endmodule
